// File: rtl/logic_gate_unit.sv
// Registered bitwise logic stage: eight selectable gate operations on WIDTH-bit
// operands, valid/ready on both sides, results held in a 2-entry FIFO.
module logic_gate_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_all
);

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_ACC  = 3'd7
  } op_e;

  logic [1:0]       count;
  logic [WIDTH:0]   entry0;
  logic [WIDTH:0]   entry1;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] result;
  logic [WIDTH:0]   new_entry;
  logic             push;
  logic             pop;

  // in_ready depends only on the registered count, never on out_ready
  assign in_ready  = rst_n && (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign y         = out_valid ? entry0[WIDTH-1:0] : '0;
  assign y_all     = out_valid & entry0[WIDTH];
  assign new_entry = {&result, result};

  always_comb begin
    result = '0;
    case (op_e'(op))
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_XNOR: result = ~(a ^ b);
      OP_NOT:  result = ~a;
      OP_ACC:  result = acc & a;
    endcase
  end

  // A clear coinciding with an accumulate still lets the result use the old acc
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '1;
    end else if (acc_clr) begin
      acc <= '1;
    end else if (push && (op_e'(op) == OP_ACC)) begin
      acc <= result;
    end
  end

  // entry0 is always the head; entry1 only holds data when count is 2
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= 2'd0;
      entry0 <= '0;
      entry1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            entry0 <= new_entry;
            count  <= 2'd1;
          end else begin
            entry1 <= new_entry;
            count  <= 2'd2;
          end
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - 2'd1;
        end
        2'b11: begin
          entry0 <= new_entry;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_gate_unit.sv
// Self-checking bench for logic_gate_unit: directed scenarios and random traffic
// on an 8-bit instance against a queue-based model, plus an exhaustive 1-bit instance.
module tb_logic_gate_unit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       acc_clr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       y_all;

  logic       in_valid_w1;
  logic       in_ready_w1;
  logic [2:0] op_w1;
  logic [0:0] a_w1;
  logic [0:0] b_w1;
  logic       acc_clr_w1;
  logic       out_valid_w1;
  logic       out_ready_w1;
  logic [0:0] y_w1;
  logic       y_all_w1;

  int check_count;
  int pass_count;

  logic [3:0] truth_tab [7];
  logic [7:0] model_q [$];
  logic [7:0] model_acc;
  logic       model_acc_w1;

  logic_gate_unit #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .acc_clr(acc_clr), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .y_all(y_all)
  );

  logic_gate_unit #(.WIDTH(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w1), .in_ready(in_ready_w1),
    .op(op_w1), .a(a_w1), .b(b_w1), .acc_clr(acc_clr_w1), .out_valid(out_valid_w1),
    .out_ready(out_ready_w1), .y(y_w1), .y_all(y_all_w1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end else begin
      pass_count++;
    end
  endtask

  // Each gate is a 4-entry truth table indexed by {a_bit, b_bit}
  function automatic logic [7:0] refGate(input int o, input logic [7:0] aa, input logic [7:0] bb,
                                         input logic [7:0] acc_v);
    logic [7:0] r;
    logic [3:0] t;
    if (o == 7) return acc_v & aa;
    t = truth_tab[o];
    for (int i = 0; i < 8; i++) r[i] = t[{aa[i], bb[i]}];
    return r;
  endfunction

  // Called #1 after a rising edge: drives inputs, checks at the falling edge, advances the model
  task automatic applyStimulus(input logic v, input int o, input logic [7:0] aa, input logic [7:0] bb,
                               input logic clr, input logic ordy, input logic rst);
    logic       accept;
    logic       pop;
    logic [7:0] r;
    logic [7:0] head;
    in_valid  = v;
    op        = o[2:0];
    a         = aa;
    b         = bb;
    acc_clr   = clr;
    out_ready = ordy;
    rst_n     = rst;
    @(negedge clk);
    head = (model_q.size() > 0) ? model_q[0] : 8'h00;
    checkOutput("in_ready", {31'd0, in_ready}, {31'd0, rst && (model_q.size() < 2)});
    checkOutput("out_valid", {31'd0, out_valid}, {31'd0, model_q.size() > 0});
    checkOutput("y", {24'd0, y}, {24'd0, head});
    checkOutput("y_all", {31'd0, y_all}, {31'd0, (model_q.size() > 0) && (head == 8'hFF)});
    accept = v && rst && (model_q.size() < 2);
    pop    = ordy && (model_q.size() > 0);
    r      = refGate(o, aa, bb, model_acc);
    @(posedge clk);
    if (!rst) begin
      model_q.delete();
      model_acc = 8'hFF;
    end else begin
      if (pop) void'(model_q.pop_front());
      if (accept) model_q.push_back(r);
      if (clr) model_acc = 8'hFF;
      else if (accept && o == 7) model_acc = r;
    end
    #1;
  endtask

  task automatic applyStimulusWidth1(input int o, input logic aa, input logic bb);
    logic [7:0] r8;
    logic       r;
    in_valid_w1  = 1'b1;
    op_w1        = o[2:0];
    a_w1         = aa;
    b_w1         = bb;
    out_ready_w1 = 1'b1;
    @(negedge clk);
    checkOutput("w1_in_ready", {31'd0, in_ready_w1}, 32'd1);
    r8 = refGate(o, {7'd0, aa}, {7'd0, bb}, {7'd0, model_acc_w1});
    r  = r8[0];
    if (o == 7) model_acc_w1 = r;
    @(posedge clk);
    #1;
    in_valid_w1 = 1'b0;
    @(negedge clk);
    checkOutput($sformatf("w1_valid_op%0d", o), {31'd0, out_valid_w1}, 32'd1);
    checkOutput($sformatf("w1_y_op%0d_a%0d_b%0d", o, aa, bb), {31'd0, y_w1}, {31'd0, r});
    checkOutput($sformatf("w1_yall_op%0d", o), {31'd0, y_all_w1}, {31'd0, r});
    @(posedge clk);
    #1;
  endtask

  initial begin
    check_count = 0;
    pass_count  = 0;
    truth_tab[0] = 4'b1000;
    truth_tab[1] = 4'b1110;
    truth_tab[2] = 4'b0110;
    truth_tab[3] = 4'b0111;
    truth_tab[4] = 4'b0001;
    truth_tab[5] = 4'b1001;
    truth_tab[6] = 4'b0011;
    model_acc    = 8'hFF;
    model_acc_w1 = 1'b1;
    in_valid = 0; op = 0; a = 0; b = 0; acc_clr = 0; out_ready = 0; rst_n = 0;
    in_valid_w1 = 0; op_w1 = 0; a_w1 = 0; b_w1 = 0; acc_clr_w1 = 0; out_ready_w1 = 0;
    @(posedge clk);
    #1;
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 1, 0);

    // Truth table with fixed operands
    for (int o = 0; o < 7; o++) applyStimulus(1, o, 8'hF0, 8'hCC, 0, 1, 1);
    repeat (2) applyStimulus(0, 0, 8'h00, 8'h00, 0, 1, 1);

    // Accumulator, including clear coinciding with an accumulate
    applyStimulus(1, 7, 8'hFE, 8'h00, 0, 1, 1);
    applyStimulus(1, 7, 8'h7F, 8'h00, 0, 1, 1);
    applyStimulus(1, 7, 8'hFF, 8'h00, 0, 1, 1);
    applyStimulus(1, 7, 8'hFF, 8'h00, 1, 1, 1);
    applyStimulus(1, 7, 8'hFF, 8'h00, 0, 1, 1);
    repeat (2) applyStimulus(0, 0, 8'h00, 8'h00, 0, 1, 1);

    // Back-pressure: third transaction must be held until space frees up
    applyStimulus(1, 0, 8'h11, 8'h11, 0, 0, 1);
    applyStimulus(1, 0, 8'h22, 8'h22, 0, 0, 1);
    applyStimulus(1, 0, 8'h33, 8'h33, 0, 0, 1);
    applyStimulus(1, 0, 8'h33, 8'h33, 0, 0, 1);
    applyStimulus(1, 0, 8'h33, 8'h33, 0, 1, 1);
    applyStimulus(1, 0, 8'h33, 8'h33, 0, 1, 1);
    repeat (3) applyStimulus(0, 0, 8'h00, 8'h00, 0, 1, 1);

    // Simultaneous push and pop at count 1
    applyStimulus(1, 1, 8'h01, 8'h00, 0, 1, 1);
    applyStimulus(1, 1, 8'h02, 8'h00, 0, 1, 1);
    applyStimulus(1, 1, 8'h04, 8'h00, 0, 1, 1);
    repeat (2) applyStimulus(0, 0, 8'h00, 8'h00, 0, 1, 1);

    // Reset with a full buffer and a non-trivial accumulator
    applyStimulus(1, 7, 8'h0F, 8'h00, 0, 0, 1);
    applyStimulus(1, 0, 8'hAA, 8'hAA, 0, 0, 1);
    applyStimulus(1, 0, 8'h55, 8'h55, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 1);
    applyStimulus(1, 7, 8'hFF, 8'h00, 0, 1, 1);
    repeat (2) applyStimulus(0, 0, 8'h00, 8'h00, 0, 1, 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), 8'($urandom),
                    8'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 49) != 0);
    end
    repeat (3) applyStimulus(0, 0, 8'h00, 8'h00, 0, 1, 1);

    // Exhaustive single-bit instance
    for (int o = 0; o < 8; o++)
      for (int ab = 0; ab < 4; ab++)
        applyStimulusWidth1(o, ab[1], ab[0]);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/logic_gate_unit.md
Name: logic_gate_unit

Overview:
- Parametrised, registered successor to the single 2-input AND gate.
- Applies one of eight selectable bitwise operations to WIDTH-bit operands:
  - six 2-input ops (AND, OR, XOR, NAND, NOR, XNOR);
  - NOT on a;
  - an accumulating AND across transactions.
- Uses a valid/ready handshake on both sides, with a 2-entry output buffer.
- Drop-in logic stage for datapaths that need back-pressure rather than a free-running gate.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  a/b/op valid this cycle
- in_ready  output  1  unit can accept a transaction
- op  input  3  operation select (see Behaviour)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- acc_clr  input  1  synchronous accumulator clear
- out_valid  output  1  y/y_all valid
- out_ready  input  1  downstream accepts result
- y  output  WIDTH  result at buffer head
- y_all  output  1  reduction-AND of y (1 when every bit of the result is 1)

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is synchronous, active-low, sampled on the rising clk edge.
- Reset, while rst_n=0 at a clk edge:
  - buffer count <= 0; acc <= all ones.
  - Outputs after the edge: out_valid=0, y=0, y_all=0.
  - in_ready=0 while rst_n=0. It goes to 1 in the first cycle with rst_n=1.
  - Reset mid-operation discards all buffered results and the accumulator.
- Handshakes:
  - Input accept when in_valid && in_ready.
  - Output pop when out_valid && out_ready.
  - in_ready = rst_n && (count < 2). It is derived from registered count only; there is no combinational path from out_ready to in_ready.
- op encoding (result r):
  - 000: a & b
  - 001: a | b
  - 010: a ^ b
  - 011: ~(a & b)
  - 100: ~(a | b)
  - 101: ~(a ^ b)
  - 110: ~a (b ignored)
  - 111: acc & a (b ignored)
- Accumulator acc (WIDTH bits, reset all ones):
  - On accept with op=111: r = acc & a, then acc <= r.
  - Other ops leave acc unchanged.
  - acc_clr=1 at an edge sets acc <= all ones.
  - If acc_clr and an op=111 accept coincide, r uses the pre-clear acc and acc ends all ones (clear wins for the stored value).
- Buffer:
  - 2-entry FIFO of {r, &r}, WIDTH+1 bits per entry.
  - Latency: accepted at edge N, visible on y/out_valid after edge N (1 cycle) when the buffer was empty.
  - out_valid = (count != 0). y/y_all show the head entry; y=0 and y_all=0 when empty.
  - Order is strictly first-in first-out.
- Count cases:
  - count=0, push: count=1.
  - count=1, push+pop same edge: count stays 1; the new entry becomes head.
  - count=1, pop only: count=0.
  - count=2: in_ready=0, so no push. A pop makes count=1 and in_ready=1 the next cycle.
  - Pop with count=0 is impossible because out_valid=0.
- Inputs are ignored when in_valid=0; a, b and op may change freely then.
- y must remain stable while out_valid=1 and out_ready=0.
- Full throughput of one transaction per cycle when out_ready is held at 1.

Test Plan:
- Truth table. WIDTH=8, out_ready=1, a=8'hF0, b=8'hCC, op 000..110, one per cycle.
  - Required y sequence: 8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'h0F, each one cycle after accept.
  - y_all=0 throughout.
- Accumulate.
  - op=111 with a=8'hFE, then 8'h7F, then 8'hFF gives y = 8'hFE, 8'h7E, 8'h7E.
  - Then acc_clr=1 with op=111 and a=8'hFF gives y=8'h7E.
  - The next op=111 with a=8'hFF gives y=8'hFF, y_all=1.
- Back-pressure.
  - out_ready=0; push op=000 with a=b=8'h11, then a=b=8'h22.
  - Required: in_ready=0 after the 2nd accept; a 3rd in_valid with a=b=8'h33 is held.
  - Raise out_ready: y=8'h11, then 8'h22, then 8'h33, with no loss or duplication.
- Simultaneous push/pop at count=1.
  - Continuous in_valid/out_ready=1 with op=001 and a = 8'h01, 8'h02, 8'h04.
  - Required: out_valid stays 1 and y = 8'h01, 8'h02, 8'h04 on consecutive cycles.
- Reset mid-operation.
  - Fill the buffer (count=2) and set acc=8'h0F, then rst_n=0 for 1 edge.
  - Required: out_valid=0, y=0, in_ready=0 during reset and 1 the cycle after.
  - Next op=111 with a=8'hFF gives y=8'hFF.
- Width generality.
  - WIDTH=1: exhaustive a,b in {0,1} for all ops.
  - y must match the 2-input gate truth table, e.g. op=000 gives y=1 only for a=b=1; y_all=y.
